// File: rtl/pipeline_rr_arbiter_if.sv
// Handshake bundle between NUM_REQ requesters, the round-robin arbiter and the
// downstream pipeline stage. master = requester/downstream side, slave = arbiter.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

interface pipeline_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ*`ADDRESS_WIDTH-1:0] req_address;
  logic [NUM_REQ*`ID_WIDTH-1:0]      req_id;
  logic [NUM_REQ-1:0]                req_stall;
  logic [`ADDRESS_WIDTH-1:0]         out_address;
  logic [`ID_WIDTH-1:0]              out_id;
  logic                              out_valid;
  logic [SRC_W-1:0]                  out_src;
  logic                              in_stall;

  modport master (
    output req_valid, req_address, req_id, in_stall,
    input  req_stall, out_address, out_id, out_valid, out_src
  );

  modport slave (
    input  req_valid, req_address, req_id, in_stall,
    output req_stall, out_address, out_id, out_valid, out_src
  );
endinterface

// File: rtl/pipeline_rr_arbiter.sv
// Round-robin arbiter feeding one registered output slot of a pipeline stage.
// Define ARB_BURST_EN to let a winner keep the slot for up to BURST_LEN grants.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module pipeline_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_rr_arbiter_if.slave  bus
);
  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;

  if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_num_req
    $error("pipeline_rr_arbiter: NUM_REQ must be 1..16");
  end
  if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
    $error("pipeline_rr_arbiter: BURST_LEN must be 1..255");
  end

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_winner;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   next_ptr;
  logic               rr_found;
  logic               load;
  logic               any_valid;
  logic [NUM_REQ-1:0] grant;
  int                 idx;

  assign load      = !bus.out_valid || !bus.in_stall;
  assign any_valid = |bus.req_valid;

  // Circular scan starting at rr_ptr; the index wraps explicitly so that
  // non-power-of-two NUM_REQ never looks at a nonexistent requester.
  always_comb begin
    rr_winner = '0;
    rr_found  = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rr_found && bus.req_valid[idx[SRC_W-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = idx[SRC_W-1:0];
      end
    end
  end

`ifdef ARB_BURST_EN
  logic [7:0]       burst_cnt;
  logic [SRC_W-1:0] last_src;
  logic             prev_grant;
  logic             lock;

  assign lock   = prev_grant && bus.req_valid[last_src] && (int'(burst_cnt) < BURST_LEN - 1);
  assign winner = lock ? last_src : rr_winner;
`else
  assign winner = rr_winner;
`endif

  assign next_ptr = (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // Reset gates every grant so all requesters see stall while reset is high.
  always_comb begin
    grant = '0;
    if (!reset && load && any_valid) grant[winner] = 1'b1;
  end

  assign bus.req_stall = ~grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.out_address <= '0;
      bus.out_id      <= '0;
      bus.out_src     <= '0;
      rr_ptr          <= '0;
`ifdef ARB_BURST_EN
      burst_cnt       <= '0;
      last_src        <= '0;
      prev_grant      <= 1'b0;
`endif
    end else if (load) begin
      if (any_valid) begin
        bus.out_valid   <= 1'b1;
        bus.out_address <= bus.req_address[int'(winner)*AW +: AW];
        bus.out_id      <= bus.req_id[int'(winner)*IW +: IW];
        bus.out_src     <= winner;
        rr_ptr          <= next_ptr;
`ifdef ARB_BURST_EN
        burst_cnt       <= lock ? burst_cnt + 8'd1 : 8'd0;
        last_src        <= winner;
        prev_grant      <= 1'b1;
`endif
      end else begin
        bus.out_valid   <= 1'b0;
`ifdef ARB_BURST_EN
        burst_cnt       <= '0;
        prev_grant      <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Directed bench for pipeline_rr_arbiter: a 4-requester instance (BURST_LEN=3)
// and a 3-requester instance (BURST_LEN=1) exercising wrap on non-power-of-two.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module tb_pipeline_rr_arbiter;
  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pipeline_rr_arbiter_if #(.NUM_REQ(4)) bus_a ();
  pipeline_rr_arbiter_if #(.NUM_REQ(3)) bus_b ();

  pipeline_rr_arbiter #(.NUM_REQ(4), .BURST_LEN(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  pipeline_rr_arbiter #(.NUM_REQ(3), .BURST_LEN(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_a(input int i, input logic [AW-1:0] addr, input logic [IW-1:0] id);
    bus_a.req_address[i*AW +: AW] = addr;
    bus_a.req_id[i*IW +: IW]      = id;
  endtask

  task automatic set_b(input int i, input logic [AW-1:0] addr, input logic [IW-1:0] id);
    bus_b.req_address[i*AW +: AW] = addr;
    bus_b.req_id[i*IW +: IW]      = id;
  endtask

  function automatic logic [3:0] stall_mask4(input int s);
    logic [3:0] m;
    m = 4'b0001 << s;
    return ~m;
  endfunction

  function automatic logic [2:0] stall_mask3(input int s);
    logic [2:0] m;
    m = 3'b001 << s;
    return ~m;
  endfunction

`ifdef ARB_BURST_EN
  int seq1[5] = '{0, 0, 0, 1, 1};
  int seq6[7] = '{0, 0, 0, 1, 1, 1, 0};
`else
  int seq1[5] = '{0, 1, 2, 3, 0};
  int seq6[7] = '{0, 1, 0, 1, 0, 1, 0};
`endif
  logic [2:0] vec3[4] = '{3'b010, 3'b011, 3'b100, 3'b111};
  int         exp3[4] = '{1, 0, 2, 0};

  initial begin
    bus_a.req_valid   = '0;
    bus_a.req_address = '0;
    bus_a.req_id      = '0;
    bus_a.in_stall    = 1'b0;
    bus_b.req_valid   = '0;
    bus_b.req_address = '0;
    bus_b.req_id      = '0;
    bus_b.in_stall    = 1'b0;
    for (int i = 0; i < 4; i++) set_a(i, AW'(16'h100 + i), IW'(8'h0A + i));
    for (int i = 0; i < 3; i++) set_b(i, AW'(16'h200 + i), IW'(8'h30 + i));
    bus_a.req_valid = 4'hF;

    // reset state, all requesters stalled while reset is high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_stall", 32'(bus_a.req_stall), 32'hF);
    check_val("rst_valid", 32'(bus_a.out_valid), 32'h0);
    check_val("rst_src",   32'(bus_a.out_src),   32'h0);
    check_val("rst_addr",  32'(bus_a.out_address), 32'h0);
    check_val("rst_id",    32'(bus_a.out_id),    32'h0);
    reset = 1'b0;
    #1;

    // all four valid, no backpressure
    for (int k = 0; k < 5; k++) begin
      check_val("t1_stall", 32'(bus_a.req_stall), 32'(stall_mask4(seq1[k])));
      @(posedge clk); #1;
      check_val("t1_src",   32'(bus_a.out_src),   32'(seq1[k]));
      check_val("t1_id",    32'(bus_a.out_id),    32'(8'h0A + seq1[k]));
      check_val("t1_valid", 32'(bus_a.out_valid), 32'h1);
      @(negedge clk);
    end

    // only requester 2, then three stalled cycles
    bus_a.req_valid = 4'b0100;
    #1;
    check_val("t2_stall", 32'(bus_a.req_stall), 32'(stall_mask4(2)));
    @(posedge clk); #1;
    check_val("t2_id",  32'(bus_a.out_id),  32'h0C);
    check_val("t2_src", 32'(bus_a.out_src), 32'h2);
    bus_a.in_stall = 1'b1;
    set_a(2, AW'(16'h1F2), IW'(8'hCE));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_val("t2_hold_stall", 32'(bus_a.req_stall), 32'hF);
      @(posedge clk); #1;
      check_val("t2_hold_id",    32'(bus_a.out_id),    32'h0C);
      check_val("t2_hold_valid", 32'(bus_a.out_valid), 32'h1);
      check_val("t2_rr_ptr",     32'(dut_a.rr_ptr),    32'h3);
    end
    @(negedge clk);
    bus_a.in_stall = 1'b0;
    #1;
    check_val("t2_release_stall", 32'(bus_a.req_stall), 32'(stall_mask4(2)));
    @(posedge clk); #1;
    check_val("t2_next_id",    32'(bus_a.out_id),      32'hCE);
    check_val("t2_next_addr",  32'(bus_a.out_address), 32'h1F2);
    check_val("t2_next_valid", 32'(bus_a.out_valid),   32'h1);

    // idle: slot empties, payload and pointer hold
    @(negedge clk);
    bus_a.req_valid = 4'b0000;
    #1;
    check_val("idle_stall", 32'(bus_a.req_stall), 32'hF);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      check_val("idle_valid",  32'(bus_a.out_valid),   32'h0);
      check_val("idle_addr",   32'(bus_a.out_address), 32'h1F2);
      check_val("idle_src",    32'(bus_a.out_src),     32'h2);
      check_val("idle_rr_ptr", 32'(dut_a.rr_ptr),      32'h3);
    end
    @(negedge clk);
    bus_a.req_valid = 4'b1001;
    #1;
    check_val("idle_resume_stall", 32'(bus_a.req_stall), 32'(stall_mask4(3)));
    @(posedge clk); #1;
    check_val("idle_resume_src",   32'(bus_a.out_src),   32'h3);
    check_val("idle_resume_id",    32'(bus_a.out_id),    32'h0D);
    check_val("idle_resume_valid", 32'(bus_a.out_valid), 32'h1);

    // reset during a held transaction drops it
    @(negedge clk);
    bus_a.in_stall  = 1'b1;
    bus_a.req_valid = 4'hF;
    reset = 1'b1;
    #1;
    check_val("t4_rst_stall", 32'(bus_a.req_stall), 32'hF);
    @(posedge clk); #1;
    check_val("t4_valid", 32'(bus_a.out_valid),   32'h0);
    check_val("t4_src",   32'(bus_a.out_src),     32'h0);
    check_val("t4_addr",  32'(bus_a.out_address), 32'h0);
    check_val("t4_id",    32'(bus_a.out_id),      32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_a.req_valid = 4'b0000;
    bus_a.in_stall  = 1'b0;
    #1;
    check_val("t4_post_stall", 32'(bus_a.req_stall), 32'hF);
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      check_val("t4_post_valid", 32'(bus_a.out_valid), 32'h0);
    end

    // requesters 0 and 1 always valid
    @(negedge clk);
    bus_a.req_valid = 4'b0011;
    #1;
    for (int k = 0; k < 7; k++) begin
      check_val("t6_stall", 32'(bus_a.req_stall), 32'(stall_mask4(seq6[k])));
      @(posedge clk); #1;
      check_val("t6_src",   32'(bus_a.out_src), 32'(seq6[k]));
      check_val("t6_id",    32'(bus_a.out_id),  32'(8'h0A + seq6[k]));
      @(negedge clk);
    end
    bus_a.req_valid = 4'b0000;

    // three requesters: pointer wrap on a non-power-of-two count
    #1;
    for (int k = 0; k < 4; k++) begin
      bus_b.req_valid = vec3[k];
      #1;
      check_val("t3_stall", 32'(bus_b.req_stall), 32'(stall_mask3(exp3[k])));
      @(posedge clk); #1;
      check_val("t3_src",   32'(bus_b.out_src),   32'(exp3[k]));
      check_val("t3_id",    32'(bus_b.out_id),    32'(8'h30 + exp3[k]));
      check_val("t3_valid", 32'(bus_b.out_valid), 32'h1);
      if (k == 2) check_val("t3_rr_wrap", 32'(dut_b.rr_ptr), 32'h0);
      @(negedge clk);
    end
    bus_b.req_valid = 3'b000;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/pipeline_rr_arbiter.md
Name: pipeline_rr_arbiter

Overview:
- Round-robin arbiter that shares one pipeline_stage input port between NUM_REQ requesters.
- Each requester presents address/id/valid and receives a stall.
- The winner is registered into a single output slot that drives the valid/stall interface of the downstream pipeline stage.
- Sits directly in front of the first pipeline_stage; throughput is 1 transfer/cycle and latency is 1 cycle.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 1..16.
- BURST_LEN, 4: maximum consecutive grants to one requester; used only with ARB_BURST_EN; legal range 1..255.
- Derived: SRC_W = max(1, $clog2(NUM_REQ)).
- Widths `ADDRESS_WIDTH and `ID_WIDTH come from defines.vh.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; one clock, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester valid.
- req_address  in  NUM_REQ*`ADDRESS_WIDTH  packed; requester i occupies bits [i*AW +: AW].
- req_id  in  NUM_REQ*`ID_WIDTH  packed, same layout.
- req_stall  out  NUM_REQ  per-requester stall.
- out_address  out  `ADDRESS_WIDTH  registered winner address.
- out_id  out  `ID_WIDTH  registered winner id.
- out_valid  out  1  output slot holds a transaction.
- out_src  out  SRC_W  index of the requester that owns the slot.
- in_stall  in  1  downstream cannot accept this cycle.

Behaviour:
- Reset (synchronous, on clk rising edge with reset=1):
  - out_valid=0, out_address=0, out_id=0, out_src=0, rr_ptr=0, burst_cnt=0.
  - Any held transaction is dropped.
  - While reset=1, req_stall = all ones.
- load = !out_valid || !in_stall (combinational).
- Winner selection: first i with req_valid[i]=1, scanning circularly from rr_ptr (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
- grant[i] = load && any(req_valid) && winner==i. Grant is one-hot or zero.
- req_stall[i] = !grant[i]; this includes reset gating.
  - Requester i transfers on an edge where req_valid[i] && !req_stall[i].
  - req_stall depends combinationally on in_stall, out_valid and req_valid; this is an accepted path.
- On an edge with load=1 and a grant:
  - out_* <= winner's address/id, out_src <= winner, out_valid <= 1.
  - rr_ptr <= (winner+1 == NUM_REQ) ? 0 : winner+1. Wrap is correct for non-power-of-2 NUM_REQ.
- On an edge with load=1 and no req_valid:
  - out_valid <= 0; out_address, out_id and out_src hold their values; rr_ptr holds.
- Hold (out_valid && in_stall):
  - All output registers hold; rr_ptr holds; all req_stall=1.
  - A requester that drops valid while stalled simply loses arbitration; no state is kept for it.
- Simultaneous downstream accept and new grant in the same cycle is a normal back-to-back transfer with no bubble.
- NUM_REQ=1: rr_ptr is constant 0 and the block degenerates to a single registered stage with the same handshake.
- Requester payload is sampled only on its transfer edge; payload values while req_valid=0 are don't-care.

Optional Feature:
- Macro: ARB_BURST_EN.
- Enabled adds:
  - Registers burst_cnt (8 bits) and last_src.
  - lock = out_valid_prev_grant && req_valid[last_src] && burst_cnt < BURST_LEN-1, where out_valid_prev_grant means the previous load edge made a grant.
- Enabled, on a load edge:
  - If lock is true: winner = last_src and burst_cnt++.
  - Otherwise: normal round-robin winner and burst_cnt <= 0.
  - last_src <= winner; rr_ptr <= winner+1 in both cases.
  - A load edge with no grant clears the lock (burst_cnt <= 0).
  - A held (stalled) cycle does not change burst_cnt or lock.
  - BURST_LEN=1 is identical to the disabled behaviour.
- Disabled: pure round-robin; burst_cnt and last_src do not exist; BURST_LEN is ignored.

Test Plan:
1. Reset, then NUM_REQ=4 with all four req_valid=1 held, ids 0xA/0xB/0xC/0xD, in_stall=0 -> out_src sequence 0,1,2,3,0,... with out_id A,B,C,D,A; out_valid=1 from cycle 1 after the first grant.
2. Only requester 2 valid, in_stall=1 for 3 cycles after the first grant -> out_id holds 0xC; req_stall[2]=1 during the stall; rr_ptr stays 3; second transfer completes the cycle in_stall drops, with no bubble.
3. NUM_REQ=3, rr_ptr=2, req_valid=3'b011 -> winner 0, rr_ptr becomes 1; then req_valid=3'b100 -> winner 2, rr_ptr wraps to 0.
4. Apply reset while out_valid=1 and in_stall=1 -> next cycle out_valid=0, out_src=0, all req_stall=1 during reset; the dropped transaction never appears downstream.
5. Idle: req_valid=0 for 5 cycles -> out_valid=0 after the first load edge; rr_ptr unchanged; out_address unchanged.
6. ARB_BURST_EN, BURST_LEN=3, requesters 0 and 1 always valid -> out_src 0,0,0,1,1,1,0,...; without the macro -> 0,1,0,1.
